// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM front-end: bus widths, burst length and
// the Wishbone bridge state encoding.
package sdram_pkg;

  localparam int SDRAM_AW = 23;
  localparam int SDRAM_DW = 16;
  localparam logic [8:0] BURST_1 = 9'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_CAP  = 3'd4,
    RD_WAIT = 3'd5,
    DONE    = 3'd6,
    FAIL    = 3'd7
  } state_t;

endpackage

// File: rtl/sdram_wb_bridge.sv
// Wishbone classic slave that turns each single-word cycle into a one-word
// SDRAM request, with a request timeout that answers with wb_err_o.
module sdram_wb_bridge
  import sdram_pkg::*;
#(
  parameter int TIMEOUT     = 512,
  parameter int RD_DATA_DLY = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [SDRAM_AW-1:0] wb_adr_i,
  input  logic [1:0]          wb_sel_i,
  input  logic [SDRAM_DW-1:0] wb_dat_i,
  output logic [SDRAM_DW-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  input  logic                sdram_init_done,
  output logic                sdram_wr_req,
  output logic                sdram_rd_req,
  input  logic                sdram_wr_ack,
  input  logic                sdram_rd_ack,
  output logic [SDRAM_AW-1:0] sys_wraddr,
  output logic [SDRAM_AW-1:0] sys_rdaddr,
  output logic [SDRAM_DW-1:0] sys_data_in,
  input  logic [SDRAM_DW-1:0] sys_data_out,
  output logic [1:0]          sdram_byteenable,
  output logic [8:0]          sdwr_byte,
  output logic [8:0]          sdrd_byte
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t              state, state_nx;
  logic [TW-1:0]       timer, timer_nx;
  logic                wr_req_nx, rd_req_nx, ack_nx, err_nx;
  logic [SDRAM_AW-1:0] wraddr_nx, rdaddr_nx;
  logic [SDRAM_DW-1:0] data_in_nx, dat_o_nx;
  logic [1:0]          be_nx;

  assign sdwr_byte = BURST_1;
  assign sdrd_byte = BURST_1;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    wr_req_nx  = sdram_wr_req;
    rd_req_nx  = sdram_rd_req;
    ack_nx     = 1'b0;
    err_nx     = 1'b0;
    wraddr_nx  = sys_wraddr;
    rdaddr_nx  = sys_rdaddr;
    data_in_nx = sys_data_in;
    dat_o_nx   = wb_dat_o;
    be_nx      = sdram_byteenable;
    case (state)
      IDLE: begin
        wr_req_nx = 1'b0;
        rd_req_nx = 1'b0;
        if (sdram_init_done && wb_cyc_i && wb_stb_i) begin
          timer_nx = '0;
          if (wb_we_i) begin
            wraddr_nx  = wb_adr_i;
            data_in_nx = wb_dat_i;
            be_nx      = wb_sel_i;
            wr_req_nx  = 1'b1;
            state_nx   = WR_REQ;
          end else begin
            rdaddr_nx = wb_adr_i;
            be_nx     = 2'b11;
            rd_req_nx = 1'b1;
            state_nx  = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (sdram_wr_ack) begin
          wr_req_nx = 1'b0;
          state_nx  = WR_WAIT;
        end else if (timer == T_LAST) begin
          wr_req_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = FAIL;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      WR_WAIT: begin
        if (!sdram_wr_ack) begin
          ack_nx   = 1'b1;
          state_nx = DONE;
        end
      end
      RD_REQ: begin
        if (sdram_rd_ack) begin
          rd_req_nx = 1'b0;
          // With a one-cycle data delay the first ack cycle carries no valid word yet.
          if (RD_DATA_DLY == 0) begin
            dat_o_nx = sys_data_out;
            state_nx = RD_WAIT;
          end else begin
            state_nx = RD_CAP;
          end
        end else if (timer == T_LAST) begin
          rd_req_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = FAIL;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      RD_CAP: begin
        dat_o_nx = sys_data_out;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (!sdram_rd_ack) begin
          ack_nx   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      FAIL:    state_nx = IDLE;
      default: begin
        wr_req_nx = 1'b0;
        rd_req_nx = 1'b0;
        state_nx  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      sdram_wr_req     <= 1'b0;
      sdram_rd_req     <= 1'b0;
      wb_ack_o         <= 1'b0;
      wb_err_o         <= 1'b0;
      wb_dat_o         <= '0;
      sys_wraddr       <= '0;
      sys_rdaddr       <= '0;
      sys_data_in      <= '0;
      sdram_byteenable <= 2'b11;
    end else begin
      state            <= state_nx;
      timer            <= timer_nx;
      sdram_wr_req     <= wr_req_nx;
      sdram_rd_req     <= rd_req_nx;
      wb_ack_o         <= ack_nx;
      wb_err_o         <= err_nx;
      wb_dat_o         <= dat_o_nx;
      sys_wraddr       <= wraddr_nx;
      sys_rdaddr       <= rdaddr_nx;
      sys_data_in      <= data_in_nx;
      sdram_byteenable <= be_nx;
    end
  end

endmodule
